smpl_sweep_ctrl: RTL

Sequencer that exhaustively exercises the 3-input / 2-output smpl_circuit combinational block. It drives A, B, C through all 8 input vectors, holds each vector for a settle time, and samples x and y. It checks the samples against a parameterised golden truth table and reports captured results, error count, first failing vector and pass/fail. It sits between a lab top-level (button/LED or host register) and the smpl_circuit instance.

---
 rtl/smpl_sweep_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/smpl_sweep_ctrl.sv
// Sweep sequencer for the 3-in/2-out smpl_circuit: walks all eight {A,B,C}
// vectors, samples x/y after a settle time and grades them against golden tables.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for start, results of last sweep held
//  S_DRIVE  | vector idx applied, counting settle cycles
//  S_SAMPLE | capture x/y for idx and grade against golden tables
//  S_DONE   | single cycle: publish done/pass, then back to idle

module smpl_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [7:0]  EXP_X       = 8'hD5,
    parameter logic [7:0]  EXP_Y       = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       x_in,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_idx,
    output logic [7:0] cap_x,
    output logic [7:0] cap_y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] abc_q, abc_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [2:0] fail_idx_q, fail_idx_d;
    logic [7:0] cap_x_q, cap_x_d;
    logic [7:0] cap_y_q, cap_y_d;
    logic       mismatch;

    assign mismatch = (x_in != EXP_X[idx_q]) || (y_in != EXP_Y[idx_q]);

    // Pin outputs are registered from the current state, so they trail the
    // state register by one cycle; an abort clears them on the same edge.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        busy_d     = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
        abc_d      = busy_d ? idx_q : 3'd0;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_idx_d = fail_idx_q;
        cap_x_d    = cap_x_q;
        cap_y_d    = cap_y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_cnt_d  = 4'd0;
                    fail_idx_d = 3'd0;
                    cap_x_d    = 8'd0;
                    cap_y_d    = 8'd0;
                    pass_d     = 1'b0;
                    idx_d      = 3'd0;
                    cnt_d      = 4'd0;
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    abc_d   = 3'd0;
                    pass_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    abc_d   = 3'd0;
                    pass_d  = 1'b0;
                end else begin
                    cap_x_d[idx_q] = x_in;
                    cap_y_d[idx_q] = y_in;
                    if (mismatch) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                        if (err_cnt_q == 4'd0) begin
                            fail_idx_d = idx_q;
                        end
                    end
                    if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = 4'd0;
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == 4'd0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 4'd0;
            abc_q      <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 4'd0;
            fail_idx_q <= 3'd0;
            cap_x_q    <= 8'd0;
            cap_y_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            abc_q      <= abc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_idx_q <= fail_idx_d;
            cap_x_q    <= cap_x_d;
            cap_y_q    <= cap_y_d;
        end
    end

    assign a_out    = abc_q[2];
    assign b_out    = abc_q[1];
    assign c_out    = abc_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_idx = fail_idx_q;
    assign cap_x    = cap_x_q;
    assign cap_y    = cap_y_q;

endmodule
